// File: rtl/output_port_arbiter.sv
// Round-robin arbiter sharing one OutputPort between several requesters.
// Each winner gets a one-cycle write strobe, then the port is held for HOLD_CYCLES.
module output_port_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 4,
    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [NUM_REQ-1:0]            Req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Data,
    output logic [NUM_REQ-1:0]            Grant,
    output logic [DATA_WIDTH-1:0]         PortData,
    output logic                          PortWrite,
    output logic                          Busy,
    output logic [LW-1:0]                 LastOwner
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        HOLD
    } arbState;

    arbState                 state;
    arbState                 stateNext;
    logic [CW-1:0]           holdCount;
    logic [CW-1:0]           holdNext;
    logic [LW-1:0]           nextPtr;
    logic [LW-1:0]           ptrNext;
    logic [DATA_WIDTH-1:0]   dataNext;
    logic [NUM_REQ-1:0]      grantNext;
    logic                    writeNext;
    logic                    busyNext;
    logic [LW-1:0]           ownerNext;

    logic                    found;
    logic [LW-1:0]           winIdx;
    logic [LW-1:0]           winNextPtr;
    logic [DATA_WIDTH-1:0]   winData;
    logic [NUM_REQ-1:0]      winGrant;
    logic [NUM_REQ-1:0]      reqShift;
    int                      candidate;

    // nextPtr is kept apart from LastOwner so the first arbitration after reset starts at 0.
    always_comb begin
        found      = 1'b0;
        winIdx     = '0;
        winNextPtr = '0;
        winData    = '0;
        winGrant   = '0;
        reqShift   = '0;
        candidate  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            candidate = int'(nextPtr) + i;
            if (candidate >= NUM_REQ) begin
                candidate = candidate - NUM_REQ;
            end
            reqShift = Req >> candidate;
            if (!found && reqShift[0]) begin
                found      = 1'b1;
                winIdx     = LW'(candidate);
                winData    = DATA_WIDTH'(Data >> (candidate * DATA_WIDTH));
                winGrant   = NUM_REQ'(1) << candidate;
                winNextPtr = (candidate == NUM_REQ - 1) ? '0 : LW'(candidate + 1);
            end
        end
    end

    always_comb begin
        stateNext = state;
        holdNext  = holdCount;
        ptrNext   = nextPtr;
        dataNext  = PortData;
        grantNext = '0;
        writeNext = 1'b0;
        ownerNext = LastOwner;
        case (state)
            IDLE: begin
                if (found) begin
                    stateNext = WRITE;
                    dataNext  = winData;
                    grantNext = winGrant;
                    writeNext = 1'b1;
                    ownerNext = winIdx;
                    ptrNext   = winNextPtr;
                end
            end
            WRITE: begin
                stateNext = HOLD;
                holdNext  = CW'(HOLD_CYCLES);
            end
            HOLD: begin
                if (holdCount <= CW'(1)) begin
                    stateNext = IDLE;
                    holdNext  = '0;
                end else begin
                    holdNext = holdCount - CW'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                holdNext  = '0;
            end
        endcase
        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= IDLE;
            holdCount <= '0;
            nextPtr   <= '0;
            PortData  <= '0;
            Grant     <= '0;
            PortWrite <= 1'b0;
            Busy      <= 1'b0;
            LastOwner <= '0;
        end else begin
            state     <= stateNext;
            holdCount <= holdNext;
            nextPtr   <= ptrNext;
            PortData  <= dataNext;
            Grant     <= grantNext;
            PortWrite <= writeNext;
            Busy      <= busyNext;
            LastOwner <= ownerNext;
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter with two requesters and a four-cycle hold.
// A negedge monitor logs every write so each scenario can be checked after it runs.
module tb_output_port_arbiter;

    logic        Clk;
    logic        Rst;
    logic [1:0]  Req;
    logic [15:0] Data;
    logic [1:0]  Grant;
    logic [7:0]  PortData;
    logic        PortWrite;
    logic        Busy;
    logic [0:0]  LastOwner;

    int checkCount = 0;
    int errorCount = 0;
    int cycleNum   = 0;
    int busyCount  = 0;
    int grantCount = 0;
    int          writeCycle[$];
    logic [7:0]  writeData[$];
    logic [1:0]  writeGrant[$];

    output_port_arbiter #(
        .NUM_REQ    (2),
        .DATA_WIDTH (8),
        .HOLD_CYCLES(4)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Req      (Req),
        .Data     (Data),
        .Grant    (Grant),
        .PortData (PortData),
        .PortWrite(PortWrite),
        .Busy     (Busy),
        .LastOwner(LastOwner)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cycleNum <= cycleNum + 1;

    always @(negedge Clk) begin
        if (Busy === 1'b1) busyCount++;
        if (Grant !== 2'b00) grantCount++;
        if (PortWrite === 1'b1) begin
            writeCycle.push_back(cycleNum);
            writeData.push_back(PortData);
            writeGrant.push_back(Grant);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic clearLog();
        writeCycle.delete();
        writeData.delete();
        writeGrant.delete();
        busyCount  = 0;
        grantCount = 0;
    endtask

    // Requesters drop their own Req bit once they have seen their Grant.
    task automatic applyStimulus(input int cycles, input bit dropOnGrant);
        for (int i = 0; i < cycles; i++) begin
            stepCycle();
            if (dropOnGrant) Req = Req & ~Grant;
        end
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic [7:0] expData, input logic [1:0] expGrant);
        if (idx < writeData.size()) begin
            checkOutput({tag, " data"}, 32'(writeData[idx]), 32'(expData));
            checkOutput({tag, " grant"}, 32'(writeGrant[idx]), 32'(expGrant));
        end else begin
            checkOutput({tag, " present"}, 32'(writeData.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        Rst  = 1'b0;
        Req  = 2'b11;
        Data = {8'd200, 8'd45};

        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("reset PortData", 32'(PortData), 32'd0);
            checkOutput("reset PortWrite", 32'(PortWrite), 32'd0);
            checkOutput("reset Grant", 32'(Grant), 32'd0);
            checkOutput("reset Busy", 32'(Busy), 32'd0);
            checkOutput("reset LastOwner", 32'(LastOwner), 32'd0);
        end

        Rst  = 1'b1;
        Req  = 2'b00;
        Data = {8'd200, 8'd123};
        stepCycle();

        $display("[TB] single request");
        clearLog();
        Req = 2'b01;
        applyStimulus(8, 1'b1);
        checkOutput("single write count", 32'(writeData.size()), 32'd1);
        checkWrite("single write", 0, 8'd123, 2'b01);
        checkOutput("single grant count", 32'(grantCount), 32'd1);
        checkOutput("single busy cycles", 32'(busyCount), 32'd5);
        checkOutput("single PortData kept", 32'(PortData), 32'd123);
        checkOutput("single Busy idle", 32'(Busy), 32'd0);

        $display("[TB] simultaneous requests");
        Rst = 1'b0;
        stepCycle();
        stepCycle();
        Rst  = 1'b1;
        Data = {8'd200, 8'd45};
        clearLog();
        Req = 2'b11;
        applyStimulus(16, 1'b1);
        checkOutput("simul write count", 32'(writeData.size()), 32'd2);
        checkWrite("simul first", 0, 8'd45, 2'b01);
        checkWrite("simul second", 1, 8'd200, 2'b10);
        if (writeCycle.size() >= 2)
            checkOutput("simul spacing", 32'(writeCycle[1] - writeCycle[0]), 32'd6);
        checkOutput("simul LastOwner", 32'(LastOwner), 32'd1);

        $display("[TB] fairness");
        clearLog();
        Req = 2'b11;
        applyStimulus(30, 1'b0);
        Req = 2'b00;
        checkOutput("fair write count", 32'(writeData.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) checkWrite($sformatf("fair %0d", i), i, 8'd45, 2'b01);
            else            checkWrite($sformatf("fair %0d", i), i, 8'd200, 2'b10);
        end

        $display("[TB] withdrawn request");
        stepCycle();
        clearLog();
        Req = 2'b01;
        stepCycle();
        Req = 2'b00;
        stepCycle();
        Req = 2'b10;
        stepCycle();
        stepCycle();
        Req = 2'b00;
        applyStimulus(6, 1'b0);
        checkOutput("withdrawn write count", 32'(writeData.size()), 32'd1);
        checkWrite("withdrawn first", 0, 8'd45, 2'b01);
        checkOutput("withdrawn grant count", 32'(grantCount), 32'd1);
        checkOutput("withdrawn Busy", 32'(Busy), 32'd0);

        $display("[TB] reset during hold");
        clearLog();
        Req = 2'b01;
        stepCycle();
        checkOutput("midhold PortWrite", 32'(PortWrite), 32'd1);
        Req = 2'b00;
        stepCycle();
        stepCycle();
        checkOutput("midhold Busy before", 32'(Busy), 32'd1);
        Rst = 1'b0;
        stepCycle();
        checkOutput("midhold Busy", 32'(Busy), 32'd0);
        checkOutput("midhold PortData", 32'(PortData), 32'd0);
        checkOutput("midhold LastOwner", 32'(LastOwner), 32'd0);
        checkOutput("midhold Grant", 32'(Grant), 32'd0);
        checkOutput("midhold PortWrite off", 32'(PortWrite), 32'd0);
        Rst = 1'b1;
        stepCycle();
        checkOutput("midhold idle after", 32'(Busy), 32'd0);
        clearLog();
        Req = 2'b11;
        applyStimulus(2, 1'b1);
        checkOutput("post reset write count", 32'(writeData.size()), 32'd1);
        checkWrite("post reset first", 0, 8'd45, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
Shares the single 7-segment OutputPort between NUM_REQ requesters, e.g. the CPU store path and the debug/monitor path.
- Round-robin arbitration; the winner gets a one-cycle Write pulse toward OutputPort plus a Grant acknowledge.
- Enforces a minimum hold time after each write so every value stays latched on the display before the next write.
- Sits between the requesters and the OutputPort Input/Write pins.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_WIDTH, 8, width of each requester's data word and of PortData
HOLD_CYCLES, 4, cycles spent in HOLD after each write (≥1)

Ports:
Clk  input  1  system clock; all state changes on the rising edge
Rst  input  1  synchronous reset, active-low; sampled on the rising edge of Clk
Req  input  NUM_REQ  per-requester write request (level)
Data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
Grant  output  NUM_REQ  one-hot acknowledge pulse, high for exactly one cycle
PortData  output  DATA_WIDTH  registered data to OutputPort Input
PortWrite  output  1  one-cycle write strobe to OutputPort Write
Busy  output  1  high whenever the FSM is not in IDLE
LastOwner  output  clog2(NUM_REQ) (min 1)  index of the most recently granted requester

Behaviour:
- All outputs are registered. No combinational path from Req/Data to any output.
- Reset (Rst=0 at a rising edge):
  - state=IDLE, PortData=0, PortWrite=0, Grant=0, Busy=0, LastOwner=0, hold counter=0.
  - Round-robin pointer set so requester 0 has highest priority on the first arbitration.
  - Reset overrides everything, including mid-WRITE or mid-HOLD; the aborted write issues no further Grant.
- FSM states: IDLE, WRITE, HOLD.
- IDLE:
  - Req sampled every edge. If Req≠0, the winner is the first set bit searching upward (with wrap) from LastOwner+1; the first arbitration after reset starts at 0.
  - At that edge: state→WRITE, PortData←Data[winner], Grant←onehot(winner), PortWrite←1, LastOwner←winner, Busy←1.
- WRITE: lasts exactly 1 cycle. At the next edge: PortWrite←0, Grant←0, counter←HOLD_CYCLES, state→HOLD.
- HOLD:
  - Counter decrements each edge; Req is ignored. PortData holds its value.
  - When the counter reaches 1, the next edge goes to IDLE and Busy←0.
- Latency: Req seen at edge k → PortWrite/Grant high in cycle k..k+1.
- Minimum spacing between PortWrite pulses is HOLD_CYCLES+2 cycles.
- Handshake:
  - A requester holds Req and Data stable until it sees Grant high, then deasserts Req on the following edge.
  - Req still high in IDLE after service counts as a new request and enters the rotation normally.
  - Req dropped before being sampled in IDLE is a withdrawn request: no grant, no write.
- PortData is never cleared except by reset; the display keeps the last value.
- Simultaneous requests: exactly one grant per arbitration; all others wait for later IDLE samples.
- Fairness: with all NUM_REQ requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0,...
- Unused high bits of a clog2 LastOwner index never occur. The pointer always stays within 0..NUM_REQ-1.

Test Plan:
(NUM_REQ=2, HOLD_CYCLES=4)
- Reset: Rst=0 for 3 cycles with Req=2'b11 → PortData=0, PortWrite=0, Grant=0, Busy=0, LastOwner=0 throughout.
- Single request: Req=01, Data0=123, drop Req after Grant:
  - PortWrite=1 for exactly 1 cycle, PortData=123, Grant=01 in the same cycle.
  - Busy high 5 cycles; PortData stays 123 afterward.
- Simultaneous requests: Req=11, Data0=45, Data1=200, each dropped after its own Grant:
  - First write 45 with Grant=01, then write 200 with Grant=10.
  - PortWrite rising edges are 6 cycles apart.
- Fairness: Req=11 held continuously for 30 cycles → Grant sequence 01,10,01,10,01; PortData alternates 45/200.
- Withdrawn request: Req0 serviced, then Req1=1 for 2 cycles inside HOLD only, then Req1=0 → no Grant=10, no second PortWrite, Busy returns to 0.
- Reset mid-HOLD: Rst=0 on the 2nd HOLD cycle:
  - Next edge gives Busy=0, PortData=0, LastOwner=0.
  - After release, Req=11 → first Grant=01.
